// File: rtl/coo_edge_scheduler.sv
// -----------------------------------------------------------------------------
// coo_edge_scheduler
//
// Sequencing controller for the GCN combination/aggregation datapath. Walks a
// two-row COO edge stream column by column, once forward (dst = row 0,
// src = row 1) and once in reverse (dst = row 1, src = row 0). Each valid edge
// issues a read of the source feature x weight row and of the destination
// accumulator row. The following cycle commits the sum back to the
// accumulator. A back-to-back edge onto the same destination row costs one
// stall cycle so the read sees the committed value.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   start          run request, honoured only in IDLE or DONE
//   coo_in[0:1]    COO rows 0/1 at coo_address (1-based ids, 0 = padding)
//   ext_read_row   accumulator read row forwarded while done_comb is high
//   coo_address    current COO column
//   read_fm_wm_row source row (src-1) on an issue, else 0
//   acc_read_row   dst-1 on an issue, ext_read_row in DONE, else 0
//   acc_write_row  accumulator write row (registered from the issue cycle)
//   acc_wr_en      accumulator write strobe (commit stage)
//   busy           high in FWD, REV and DRAIN
//   done_comb      high in DONE
//   stall_count    hazard stalls in the current/last run, saturating at 255
// -----------------------------------------------------------------------------
module coo_edge_scheduler #(
    parameter int COO_COLS    = 6,
    parameter int COO_BW      = $clog2(COO_COLS),
    parameter int FM_WM_ROWS  = 6,
    parameter int FM_WM_WIDTH = $clog2(FM_WM_ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COO_BW-1:0]      coo_in [0:1],
    input  logic [FM_WM_WIDTH-1:0] ext_read_row,
    output logic [COO_BW-1:0]      coo_address,
    output logic [FM_WM_WIDTH-1:0] read_fm_wm_row,
    output logic [FM_WM_WIDTH-1:0] acc_read_row,
    output logic [FM_WM_WIDTH-1:0] acc_write_row,
    output logic                   acc_wr_en,
    output logic                   busy,
    output logic                   done_comb,
    output logic [7:0]             stall_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_REV,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [COO_BW-1:0] LAST_COL = COO_BW'(COO_COLS - 1);

    state_e                   state_q,     state_d;
    logic [COO_BW-1:0]        coo_addr_q,  coo_addr_d;
    logic                     pend_q,      pend_d;
    logic [FM_WM_WIDTH-1:0]   wr_row_q,    wr_row_d;
    logic [7:0]               stall_cnt_q, stall_cnt_d;

    logic                     in_pass;
    logic [COO_BW-1:0]        dst, src;
    logic [COO_BW-1:0]        dst_m1, src_m1;
    logic [FM_WM_WIDTH-1:0]   dst_row, src_row;
    logic                     edge_valid;
    logic                     hazard;
    logic                     issue;
    logic                     advance;

    // Edge decode: which row is the destination depends on the pass.
    // NOTE: every signal driven here gets a default at the top of the block so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        in_pass = (state_q == S_FWD) || (state_q == S_REV);
        dst     = coo_in[0];
        src     = coo_in[1];
        if (state_q == S_REV) begin
            dst = coo_in[1];
            src = coo_in[0];
        end
        dst_m1  = dst - COO_BW'(1);
        src_m1  = src - COO_BW'(1);
        dst_row = FM_WM_WIDTH'(dst_m1);
        src_row = FM_WM_WIDTH'(src_m1);

        // A reverse self-loop was already aggregated in the forward pass.
        edge_valid = in_pass && (dst != '0) && (src != '0) &&
                     !((state_q == S_REV) && (coo_in[0] == coo_in[1]));

        // The pending commit still holds last cycle's dst-1, so comparing rows
        // is the same as comparing destinations. The pending flag is not
        // cleared at the FWD->REV boundary, so hazards span it.
        hazard  = edge_valid && pend_q && (dst_row == wr_row_q);
        issue   = edge_valid && !hazard;
        advance = in_pass && !hazard;
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        coo_addr_d  = coo_addr_q;
        pend_d      = issue;
        wr_row_d    = issue ? dst_row : wr_row_q;
        stall_cnt_d = stall_cnt_q;

        if (hazard && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_FWD;
                    coo_addr_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            S_FWD, S_REV: begin
                if (advance) begin
                    if (coo_addr_q == LAST_COL) begin
                        coo_addr_d = '0;
                        state_d    = (state_q == S_FWD) ? S_REV : S_DRAIN;
                    end else begin
                        coo_addr_d = coo_addr_q + COO_BW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // The last issue commits during this cycle.
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            coo_addr_q  <= '0;
            pend_q      <= 1'b0;
            wr_row_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            coo_addr_q  <= coo_addr_d;
            pend_q      <= pend_d;
            wr_row_q    <= wr_row_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs.
    always_comb begin
        read_fm_wm_row = '0;
        acc_read_row   = '0;
        if (issue) begin
            read_fm_wm_row = src_row;
            acc_read_row   = dst_row;
        end else if (state_q == S_DONE) begin
            acc_read_row   = ext_read_row;
        end
    end

    assign coo_address   = coo_addr_q;
    assign acc_write_row = wr_row_q;
    assign acc_wr_en     = pend_q;
    assign busy          = (state_q == S_FWD) || (state_q == S_REV) ||
                           (state_q == S_DRAIN);
    assign done_comb     = (state_q == S_DONE);
    assign stall_count   = stall_cnt_q;

endmodule

// File: doc/coo_edge_scheduler.md
# coo_edge_scheduler

Sequencing controller for the GCN combination/aggregation datapath. It walks the two-row COO edge stream column by column and, for each edge, issues a read of the source feature×weight row and a read of the destination accumulator row. One cycle later it commits the sum back to the accumulator memory. It runs a forward pass (dst = row 0) followed by a reverse pass (dst = row 1), inserts a one-cycle stall on read-after-write hazards, skips padding and reverse self-loops, and raises `done_comb` when the accumulator is final.

## Interface
Parameters
- `COO_COLS`, 6: number of COO columns (edges).
- `COO_BW`, `$clog2(COO_COLS)`: width of COO entries and of `coo_address`. COO entries are 1-based node ids; 0 marks padding.
- `FM_WM_ROWS`, 6: number of nodes (feature×weight rows).
- `FM_WM_WIDTH`, `$clog2(FM_WM_ROWS)`: row index width.

Ports
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: pulse that begins a run. Accepted only in IDLE or DONE.
- `coo_in[0:1]`, in, `COO_BW` each: row 0 and row 1 of the COO column at `coo_address`, valid in the same cycle.
- `ext_read_row`, in, `FM_WM_WIDTH`: accumulator read row used while `done_comb`=1.
- `coo_address`, out, `COO_BW`: current COO column.
- `read_fm_wm_row`, out, `FM_WM_WIDTH`: source row to the FM×WM memory. Equals src−1.
- `acc_read_row`, out, `FM_WM_WIDTH`: accumulator read row. Equals dst−1, or `ext_read_row` in DONE.
- `acc_write_row`, out, `FM_WM_WIDTH`: accumulator write row, registered from the issuing cycle.
- `acc_wr_en`, out, 1: accumulator write strobe (commit stage).
- `busy`, out, 1: high in FWD, REV and DRAIN.
- `done_comb`, out, 1: level, high in DONE.
- `stall_count`, out, 8: number of hazard stalls in the current or last run. Saturates at 255.

## Operation
- States: IDLE, FWD, REV, DRAIN, DONE.
- IDLE/DONE with `start`=1 → FWD. Entering FWD clears `coo_address` and `stall_count`.
- `start` is ignored while `busy`.
- Per-cycle edge selection:
  - FWD: dst = `coo_in[0]`, src = `coo_in[1]`.
  - REV: dst = `coo_in[1]`, src = `coo_in[0]`.
- An edge is valid unless dst==0 or src==0. In REV it is also invalid when `coo_in[0]`==`coo_in[1]` (a self-loop counts once).
- Hazard: the current edge is valid, the previous cycle issued a valid edge, and the current dst equals that edge's dst. On a hazard:
  - the scheduler stalls;
  - no issue occurs and `coo_address` holds;
  - `stall_count` increments.
- Issue (valid, no hazard):
  - drive `read_fm_wm_row`=src−1 and `acc_read_row`=dst−1;
  - register dst−1 and a pending flag;
  - advance `coo_address`.
- Invalid edge: no issue, no pending flag; `coo_address` advances (the cycle is consumed).
- Commit: the cycle after an issue, `acc_wr_en`=1 and `acc_write_row`=the registered row. The datapath's sum uses the 1-cycle-latency read data.
- Pass transitions:
  - The cycle that consumes column `COO_COLS`−1 in FWD → REV; `coo_address` wraps to 0.
  - The same event in REV → DRAIN.
  - DRAIN lasts 1 cycle and completes the last commit, then → DONE.
- Hazard detection spans the FWD→REV boundary.
- In DONE, `acc_read_row`=`ext_read_row`, `read_fm_wm_row`=0 and `acc_wr_en`=0.
- Reset at any time: state → IDLE and every output → 0. A pending commit is dropped.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` sampled high at cycle 0 → FWD at cycle 1, column 0 issued at cycle 1.
- Total run time: C = `COO_COLS`, S = stalls.
  - FWD occupies C+S_f cycles; REV occupies C+S_r cycles.
  - DRAIN takes 1 cycle.
  - `done_comb` rises at cycle 2C+S+2. For C=6 with no stalls, that is cycle 14.
- Issue→commit latency is exactly 1 cycle. `acc_wr_en` is never asserted two cycles after an issue.
- At most one write per cycle; writes never overlap an issue to the same row.
- `done_comb` stays high until a new `start` or `reset`. A new `start` in DONE drops `done_comb` on the next cycle.

## Test plan
- Reset mid-FWD at column 3 → next cycle: IDLE, all outputs 0, no `acc_wr_en`. A subsequent `start` restarts at column 0.
- Distinct edges row0={1,2,3,4,5,6}, row1={2,3,4,5,6,1} → no stalls, 12 `acc_wr_en` pulses, `done_comb` at cycle 14, `stall_count`=0.
- row0={1,1,2,3,0,4}, row1={2,3,3,3,0,4} → `stall_count`=2 and 8 writes:
  - FWD: 5 writes to rows 0,0,1,2,3.
  - REV: 3 writes to rows 1,2,2.
  - Column 4 (padding) and the REV self-loops at columns 3 and 5 are skipped.
  - `done_comb` at cycle 16.
- Hazard across the pass boundary: last FWD dst=5 and first REV dst=5 → exactly 1 stall at the boundary, and the write to row 4 occurs before the REV read of row 4.
- `start` pulsed during FWD and during DRAIN → ignored, and the run completes unchanged.
- In DONE, `ext_read_row`=3 → `acc_read_row`=3 in the same cycle, and `acc_wr_en`=0.
